nv_clk_gate_ctrl_multi: RTL and testbench

- Parametrised multi-channel power clock-gating controller. Generalises the single-channel enable-driven gate.
- Each channel has an idle-hysteresis counter, a wake-up delay and a ready handshake. Downstream logic is clocked only after its gated clock is stable.
- Sits between the core clock root and NUM_CH sub-unit clock domains. Each channel's registered enable drives one latch-based ICG cell (CKLNQD12, TE tied 0).

---
 rtl/nv_clk_gate_ctrl_multi.sv | 155 +++++++++++++++
 tb/tb_nv_clk_gate_ctrl_multi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_clk_gate_ctrl_multi.sv
// Multi-channel clock-gating controller: per-channel idle hysteresis, wake delay and ready handshake.
// Optional macros: NV_CLK_GATE_STATS_EN (OFF-cycle counters), VLIB_BYPASS_POWER_CG (gated clocks follow clk).
module nv_clk_gate_ctrl_multi #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_W   = 3,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_gate_en,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_force_on,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic [NUM_CH-1:0] ch_clk_gated,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_is_gated
`ifdef NV_CLK_GATE_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [NUM_CH*32-1:0] ch_gated_cycles
`endif
);

    typedef enum logic [1:0] {ST_ON, ST_COUNT, ST_OFF, ST_WAKE} state_e;

    localparam logic [WAKE_W-1:0] WAKE_INIT = WAKE_W'(WAKE_CYC);

    state_e            state_q    [NUM_CH];
    state_e            state_d    [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt_q [NUM_CH];
    logic [IDLE_W-1:0] idle_cnt_d [NUM_CH];
    logic [WAKE_W-1:0] wake_cnt_q [NUM_CH];
    logic [WAKE_W-1:0] wake_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] wake_c;

    assign wake_c = ch_busy | ch_req | ch_force_on | {NUM_CH{~cfg_gate_en}};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
            state_d[i]    = state_q[i];
            idle_cnt_d[i] = idle_cnt_q[i];
            wake_cnt_d[i] = wake_cnt_q[i];
            unique case (state_q[i])
                ST_ON: begin
                    if (!wake_c[i]) begin
                        state_d[i]    = ST_COUNT;
                        idle_cnt_d[i] = '0;
                    end
                end
                ST_COUNT: begin
                    if (wake_c[i]) begin
                        state_d[i]    = ST_ON;
                        idle_cnt_d[i] = '0;
                    end else if (idle_cnt_q[i] >= idle_thresh) begin
                        state_d[i] = ST_OFF;
                    end else if (idle_cnt_q[i] != '1) begin
                        idle_cnt_d[i] = idle_cnt_q[i] + IDLE_W'(1);
                    end
                end
                ST_OFF: begin
                    if (wake_c[i]) begin
                        state_d[i]    = (WAKE_CYC == 0) ? ST_ON : ST_WAKE;
                        wake_cnt_d[i] = WAKE_INIT;
                        idle_cnt_d[i] = '0;
                    end
                end
                ST_WAKE: begin
                    // The wake sequence always completes; wake_c is deliberately not consulted here.
                    if (wake_cnt_q[i] <= WAKE_W'(1)) begin
                        state_d[i]    = ST_ON;
                        wake_cnt_d[i] = '0;
                    end else begin
                        wake_cnt_d[i] = wake_cnt_q[i] - WAKE_W'(1);
                    end
                end
                default: state_d[i] = ST_ON;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all channels update from pre-edge values.
        if (reset) begin
            // NOTE: the per-channel state arrays are control state, so every entry is reset, not just the first.
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= ST_ON;
                idle_cnt_q[i] <= '0;
                wake_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= state_d[i];
                idle_cnt_q[i] <= idle_cnt_d[i];
                wake_cnt_q[i] <= wake_cnt_d[i];
            end
        end
    end

    // Outputs decode the state register only, so they change once per edge and never glitch.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_clk_en[i]   = (state_q[i] != ST_OFF);
            ch_ready[i]    = (state_q[i] == ST_ON) || (state_q[i] == ST_COUNT);
            ch_is_gated[i] = (state_q[i] == ST_OFF);
        end
    end

`ifdef VLIB_BYPASS_POWER_CG
    assign ch_clk_gated = {NUM_CH{clk}};
`else
    // Behavioural model of the latch-based ICG: enable is captured while clk is low.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_icg
        logic en_lat;
        always_latch begin
            if (!clk) en_lat <= ch_clk_en[g];
        end
        assign ch_clk_gated[g] = clk & en_lat;
    end
`endif

`ifdef NV_CLK_GATE_STATS_EN
    logic [31:0] gated_cnt_q [NUM_CH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || stats_clr) begin
                gated_cnt_q[i] <= '0;
            end else if ((state_q[i] == ST_OFF) && (gated_cnt_q[i] != '1)) begin
                gated_cnt_q[i] <= gated_cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_gated_cycles[i*32 +: 32] = gated_cnt_q[i];
        end
    end
`endif

`ifndef SYNTHESIS
`ifndef DISABLE_NV_CLK_GATE_ASSERTS
    a_no_x: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({ch_clk_en, ch_ready, ch_clk_gated}));

    a_ready_implies_en: assert property (@(posedge clk) disable iff (reset)
        (ch_ready & ~ch_clk_en) == '0);
`endif
`endif

endmodule

// File: tb/tb_nv_clk_gate_ctrl_multi.sv
// Self-checking bench for nv_clk_gate_ctrl_multi: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_nv_clk_gate_ctrl_multi;

    localparam int NUM_CH   = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_W   = 3;
    localparam int WAKE_CYC = 2;

    logic              clk         = 1'b0;
    logic              reset       = 1'b1;
    logic              cfg_gate_en = 1'b1;
    logic [IDLE_W-1:0] idle_thresh = 8'd3;
    logic [NUM_CH-1:0] ch_busy     = '0;
    logic [NUM_CH-1:0] ch_req      = '0;
    logic [NUM_CH-1:0] ch_force_on = '0;
    logic [NUM_CH-1:0] ch_clk_en;
    logic [NUM_CH-1:0] ch_clk_gated;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_is_gated;
`ifdef NV_CLK_GATE_STATS_EN
    logic                 stats_clr = 1'b0;
    logic [NUM_CH*32-1:0] ch_gated_cycles;
    longint               m_stat [NUM_CH];
`endif

    int tests = 0;
    int fails = 0;

    // Model: a channel is either gated, waking (m_wake_left > 0) or running with a run of idle samples.
    bit                m_gated     [NUM_CH];
    int                m_wake_left [NUM_CH];
    int                m_idle_run  [NUM_CH];
    logic [NUM_CH-1:0] m_prev_en = '1;

    nv_clk_gate_ctrl_multi #(
        .NUM_CH(NUM_CH), .IDLE_W(IDLE_W), .WAKE_W(WAKE_W), .WAKE_CYC(WAKE_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_gate_en  (cfg_gate_en),
        .idle_thresh  (idle_thresh),
        .ch_busy      (ch_busy),
        .ch_req       (ch_req),
        .ch_force_on  (ch_force_on),
        .ch_clk_en    (ch_clk_en),
        .ch_clk_gated (ch_clk_gated),
        .ch_ready     (ch_ready),
        .ch_is_gated  (ch_is_gated)
`ifdef NV_CLK_GATE_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .ch_gated_cycles (ch_gated_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CH-1:0] exp_en();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = !m_gated[i];
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_rdy();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = !m_gated[i] && (m_wake_left[i] == 0);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_gtd();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_gated[i];
        return r;
    endfunction

    function automatic logic [3*NUM_CH-1:0] exp_vec();
        return {exp_en(), exp_rdy(), exp_gtd()};
    endfunction

    task automatic model_edge();
        bit wk;
        int cap = (1 << IDLE_W) - 1;
        int held;
        m_prev_en = exp_en();
`ifdef NV_CLK_GATE_STATS_EN
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || stats_clr) m_stat[i] = 0;
            else if (m_gated[i] && m_stat[i] < 64'hFFFF_FFFF) m_stat[i]++;
        end
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            wk = ch_busy[i] | ch_req[i] | ch_force_on[i] | !cfg_gate_en;
            if (reset) begin
                m_gated[i] = 0; m_wake_left[i] = 0; m_idle_run[i] = 0;
            end else if (m_gated[i]) begin
                if (wk) begin
                    m_gated[i] = 0; m_wake_left[i] = WAKE_CYC; m_idle_run[i] = 0;
                end
            end else if (m_wake_left[i] > 0) begin
                m_wake_left[i]--;
            end else if (wk) begin
                m_idle_run[i] = 0;
            end else begin
                // Idle samples beyond the first one are what count against the threshold.
                held = (m_idle_run[i] - 1 > cap) ? cap : m_idle_run[i] - 1;
                if (m_idle_run[i] >= 1 && held >= int'(idle_thresh)) begin
                    m_gated[i] = 1; m_idle_run[i] = 0;
                end else begin
                    m_idle_run[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step();
            tests++;
            if (ch_clk_en !== '1 || ch_ready !== '1 || ch_is_gated !== '0) begin
                fails++;
                $display("FAIL reset_state en=%b rdy=%b gtd=%b exp en=1111 rdy=1111 gtd=0000",
                         ch_clk_en, ch_ready, ch_is_gated);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (ch_clk_en !== ((k >= 5) ? 4'h0 : 4'hF) || ch_is_gated !== ((k >= 5) ? 4'hF : 4'h0)) begin
                fails++;
                $display("FAIL release_gate k=%0d en=%b gtd=%b", k, ch_clk_en, ch_is_gated);
            end
            tests++;
            if ({ch_clk_en, ch_ready, ch_is_gated} !== exp_vec()) begin
                fails++;
                $display("FAIL release_model k=%0d got %h exp %h", k, {ch_clk_en, ch_ready, ch_is_gated}, exp_vec());
            end
        end
    endtask

    task automatic test_wake_req();
        ch_req = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            step();
            ch_req = '0;
            tests++;
            if (ch_clk_en[0] !== 1'b1 || ch_ready[0] !== (k == 3) || ch_is_gated[3:1] !== 3'b111) begin
                fails++;
                $display("FAIL wake_req k=%0d en0=%b rdy0=%b gtd=%b exp en0=1 rdy0=%0d gtd=111x",
                         k, ch_clk_en[0], ch_ready[0], ch_is_gated, (k == 3));
            end
        end
    endtask

    task automatic test_busy_recount();
        ch_busy = '1;
        repeat (4) step();
        ch_busy = '0;
        repeat (3) step();
        ch_busy = '1;
        step();
        ch_busy = '0;
        for (int k = 1; k <= 5; k++) begin
            step();
            tests++;
            if (ch_clk_en !== ((k == 5) ? 4'h0 : 4'hF)) begin
                fails++;
                $display("FAIL busy_recount k=%0d en=%b exp %b", k, ch_clk_en, (k == 5) ? 4'h0 : 4'hF);
            end
            tests++;
            if ({ch_clk_en, ch_ready, ch_is_gated} !== exp_vec()) begin
                fails++;
                $display("FAIL recount_model k=%0d got %h exp %h", k, {ch_clk_en, ch_ready, ch_is_gated}, exp_vec());
            end
        end
    endtask

    task automatic test_cfg_drop();
        cfg_gate_en = 1'b0;
        ch_force_on = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
            tests++;
            if (ch_clk_en !== 4'hF || ch_ready !== ((k == 3) ? 4'hF : 4'h0)) begin
                fails++;
                $display("FAIL cfg_drop k=%0d en=%b rdy=%b", k, ch_clk_en, ch_ready);
            end
        end
        cfg_gate_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            tests++;
            if (ch_clk_en[2] !== 1'b1 || ch_ready[2] !== 1'b1) begin
                fails++;
                $display("FAIL force_on k=%0d en2=%b rdy2=%b exp 1 1", k, ch_clk_en[2], ch_ready[2]);
            end
        end
        tests++;
        if (ch_is_gated !== 4'b1011) begin
            fails++;
            $display("FAIL force_on_final gtd=%b exp 1011", ch_is_gated);
        end
    endtask

    task automatic test_reset_in_wake();
        ch_force_on = '0;
        ch_req      = 4'b0010;
        step();
        ch_req = '0;
        tests++;
        if (ch_clk_en[1] !== 1'b1 || ch_ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL wake_entry en1=%b rdy1=%b exp 1 0", ch_clk_en[1], ch_ready[1]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (ch_clk_en !== 4'hF || ch_ready !== 4'hF || ch_is_gated !== 4'h0) begin
            fails++;
            $display("FAIL reset_in_wake en=%b rdy=%b gtd=%b exp 1111 1111 0000", ch_clk_en, ch_ready, ch_is_gated);
        end
    endtask

    task automatic test_random();
        int act = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) act = $urandom_range(0, 2);
            if ($urandom_range(0, 63) == 0) idle_thresh = IDLE_W'($urandom_range(0, 6));
            reset       = ($urandom_range(0, 299) == 0);
            cfg_gate_en = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_busy[i]     = (act == 2) ? ($urandom_range(0, 3) == 0) :
                                 (act == 1) ? ($urandom_range(0, 29) == 0) : 1'b0;
                ch_req[i]      = ($urandom_range(0, 39) == 0);
                ch_force_on[i] = ($urandom_range(0, 199) == 0);
            end
`ifdef NV_CLK_GATE_STATS_EN
            stats_clr = ($urandom_range(0, 99) == 0);
`endif
            step();
            tests++;
            if ({ch_clk_en, ch_ready, ch_is_gated} !== exp_vec()) begin
                fails++;
                $display("FAIL random_state n=%0d got %h exp %h", n, {ch_clk_en, ch_ready, ch_is_gated}, exp_vec());
            end
            if (n > 0) begin
                tests++;
`ifdef VLIB_BYPASS_POWER_CG
                if (ch_clk_gated !== 4'hF) begin
`else
                if (ch_clk_gated !== m_prev_en) begin
`endif
                    fails++;
                    $display("FAIL random_gated_clk n=%0d got %b prev_en %b", n, ch_clk_gated, m_prev_en);
                end
            end
`ifdef NV_CLK_GATE_STATS_EN
            for (int i = 0; i < NUM_CH; i++) begin
                tests++;
                if (longint'(ch_gated_cycles[i*32 +: 32]) !== m_stat[i]) begin
                    fails++;
                    $display("FAIL random_stats n=%0d ch=%0d got %0d exp %0d", n, i, ch_gated_cycles[i*32 +: 32], m_stat[i]);
                end
            end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wake_req();
        test_busy_recount();
        test_cfg_drop();
        test_reset_in_wake();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
